rr_arbiter16: RTL and testbench
===============================

// Module: rr_arbiter16
// PURPOSE
// - Round-robin arbiter sharing a single resource among up to 16 requesters.
// - Grant is held until the owner releases it, drops its request, or a hold watchdog expires.
// - Grant is driven as both a binary index and a one-hot vector (4:16 style decode).
// - Sits in front of shared datapath resources (bus, memory port, LUT).
// PARAMETERS
// - N         16  number of requesters, 2..16
// - IDX_W     4   width of grant index; must satisfy 2**IDX_W >= N
// - MAX_HOLD  64  max cycles a grant may be held; 0 disables the watchdog
// PORTS
// - clk         in   1      clock; all logic on rising edge
// - rst         in   1      synchronous reset, active-high
// - reqIn       in   N      request per requester; level, held while wanting access
// - relIn       in   1      release strobe from current owner; ignored when grantValid=0
// - grantValid  out  1      a grant is active
// - grantIdx    out  IDX_W  binary index of current owner; holds last value when grantValid=0
// - grantOut    out  N      one-hot grant; all-zero when grantValid=0
// - timeoutOut  out  1      one-cycle pulse: grant revoked by watchdog
// BEHAVIOUR
// - Reset values: grantValid=0, grantIdx=0, grantOut=0, timeoutOut=0.
//   Internal: priority pointer ptr=0, hold counter=0, state IDLE.
// - Registers: every output is registered; grantOut = grantValid ? (1<<grantIdx) : 0.
// - IDLE state, if reqIn != 0:
//   - Winner = first set bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
//   - At the next edge: grantIdx=winner, grantValid=1, counter=0, state -> GRANT.
//   - Latency: request sampled at edge k -> grant visible after edge k+1.
// - IDLE state, if reqIn == 0: nothing changes.
// - GRANT state, checked each edge:
//   - Counter increments, saturating at MAX_HOLD.
//   - Release condition = relIn | ~reqIn[grantIdx] | (MAX_HOLD!=0 && counter==MAX_HOLD-1).
//   - On release: grantValid=0, ptr=(grantIdx+1) mod N, state -> IDLE.
//   - Hence at least one idle cycle between consecutive grants.
// - timeoutOut: pulses 1 for exactly the cycle after a release caused only by the watchdog.
//   - If relIn or request drop coincides with expiry, no timeout pulse.
// - Other requesters' reqIn changes during GRANT do not affect the current grant.
// - Bits of reqIn at index >= N: do not exist; the pointer wraps at N, not 2**IDX_W.
// - Reset asserted mid-grant: all outputs return to reset values at that edge; ptr returns to 0.
// - Starvation-free: with all requesters continuously requesting, each is granted once per N grants.
// TESTING
// - Reset, then reqIn=16'h0001 at edge 1, relIn at edge 5 -> grantOut=0x0001 edges 2..5; grantValid=0 after edge 6.
// - reqIn=16'hFFFF constant, relIn pulsed 1 cycle after each grant -> grantIdx sequence 0,1,2..15,0 (wrap).
// - After owner 3 releases, reqIn=0x0009 -> next grant goes to 0 (wrap from ptr=4), not 3.
// - MAX_HOLD=4, reqIn=0x0100 held, no relIn -> grant active 4 cycles; timeoutOut=1 for 1 cycle; regrant to 8 after idle cycle.
// - Owner 5 drops reqIn[5] while 0x0060 pending -> grant revoked next edge, timeoutOut=0; next grant to 6.
// - rst asserted while grantValid=1 -> next cycle all outputs 0; with reqIn=0xFFFF, first grant after reset is 0.

Source files
------------

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter for up to 16 requesters.
// A grant is held until the owner strobes relIn, drops its request, or the
// hold watchdog expires. The owner is reported both as a binary index and as
// a one-hot vector, and every output comes straight from a flop.
module rr_arbiter16 #(
    parameter int N        = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     reqIn,
    input  logic             relIn,
    output logic             grantValid,
    output logic [IDX_W-1:0] grantIdx,
    output logic [N-1:0]     grantOut,
    output logic             timeoutOut
);

    // The counter must be able to hold MAX_HOLD itself, because it saturates there.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IDX_W:0]   N_EXT     = (IDX_W + 1)'(N);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0]     grant_out_q, grant_out_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W:0]   cand;
    logic             wd_expire;
    logic             owner_drop;

    // Pick the first requester at or after ptr, wrapping at N rather than at 2**IDX_W.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && reqIn[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state logic: claim in IDLE, then hold or release in GRANT.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        timeout_d     = 1'b0;
        wd_expire     = 1'b0;
        owner_drop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_idx_d   = winner;
                    grant_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_GRANT;
                end
            end
            default: begin
                if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                wd_expire  = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
                owner_drop = !reqIn[grant_idx_q];
                if (relIn || owner_drop || wd_expire) begin
                    grant_valid_d = 1'b0;
                    ptr_d         = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + 1'b1;
                    state_d       = S_IDLE;
                    // The pulse is reserved for a release the owner did not ask for.
                    timeout_d     = wd_expire && !relIn && !owner_drop;
                end
            end
        endcase

        // The one-hot output is decoded from the next index so that it can be registered too.
        grant_out_d = '0;
        for (int i = 0; i < N; i++) begin
            grant_out_d[i] = grant_valid_d && (grant_idx_d == IDX_W'(i));
        end
    end

    // State and output registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the values from before the edge.
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            grant_out_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            grant_out_q   <= grant_out_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grantValid = grant_valid_q;
    assign grantIdx   = grant_idx_q;
    assign grantOut   = grant_out_q;
    assign timeoutOut = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed test of rr_arbiter16 with a short watchdog (MAX_HOLD=4).
// Inputs change 1 ns after a rising edge, and outputs are checked at the same point.
module tb_rr_arbiter16;

    localparam int N        = 16;
    localparam int IDX_W    = 4;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     reqIn;
    logic             relIn;
    logic             grantValid;
    logic [IDX_W-1:0] grantIdx;
    logic [N-1:0]     grantOut;
    logic             timeoutOut;

    int checks = 0;
    int errors = 0;

    rr_arbiter16 #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .reqIn      (reqIn),
        .relIn      (relIn),
        .grantValid (grantValid),
        .grantIdx   (grantIdx),
        .grantOut   (grantOut),
        .timeoutOut (timeoutOut)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all four outputs of the arbiter at once.
    task automatic check_all(input string tag, input logic v, input logic [IDX_W-1:0] idx,
                             input logic [N-1:0] onehot, input logic to);
        check({tag, ".valid"},   32'(v),      32'(grantValid));
        check({tag, ".idx"},     32'(grantIdx), 32'(idx));
        check({tag, ".onehot"},  32'(grantOut), 32'(onehot));
        check({tag, ".timeout"}, 32'(timeoutOut), 32'(to));
    endtask

    initial begin
        rst   = 1'b1;
        reqIn = '0;
        relIn = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst = 1'b0;

        // Single requester: granted on the next edge, released by relIn.
        // The relIn edge is also the watchdog expiry, so there is no timeout pulse.
        reqIn = 16'h0001;
        tick();
        check_all("t1_grant", 1'b1, 4'd0, 16'h0001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t1_hold", 32'(grantOut), 32'h0001);
        end
        relIn = 1'b1;
        tick();
        relIn = 1'b0;
        check_all("t1_release", 1'b0, 4'd0, 16'h0000, 1'b0);
        reqIn = '0;
        tick();
        check("t1_idle", 32'(grantValid), 32'd0);

        // All requesting: the grant order walks 0..15 and wraps back to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reqIn = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            tick();
            check("rr_idx", 32'(grantIdx), 32'(k % 16));
            check("rr_onehot", 32'(grantOut), 32'h1 << (k % 16));
            relIn = 1'b1;
            tick();
            relIn = 1'b0;
            check("rr_gap", 32'(grantValid), 32'd0);
        end

        // ptr is now 1. Grant 3, release it, then requesters 0 and 3: scanning from 4 wraps to 0.
        reqIn = 16'h0008;
        tick();
        check_all("t3_grant3", 1'b1, 4'd3, 16'h0008, 1'b0);
        relIn = 1'b1;
        reqIn = 16'h0009;
        tick();
        relIn = 1'b0;
        check("t3_release", 32'(grantValid), 32'd0);
        tick();
        check_all("t3_wrap", 1'b1, 4'd0, 16'h0001, 1'b0);
        relIn = 1'b1;
        tick();
        relIn = 1'b0;
        reqIn = '0;

        // Watchdog: 4 cycles held, then a 1-cycle timeout pulse, then a regrant after 1 idle cycle.
        reqIn = 16'h0100;
        tick();
        check_all("wd_grant", 1'b1, 4'd8, 16'h0100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all("wd_hold", 1'b1, 4'd8, 16'h0100, 1'b0);
        end
        tick();
        check_all("wd_expire", 1'b0, 4'd8, 16'h0000, 1'b1);
        tick();
        check_all("wd_regrant", 1'b1, 4'd8, 16'h0100, 1'b0);
        reqIn = '0;
        tick();
        check_all("wd_drop", 1'b0, 4'd8, 16'h0000, 1'b0);

        // ptr is now 9. Owner 5 drops its request while 6 waits: revoked without a timeout, then 6 is granted.
        reqIn = 16'h0060;
        tick();
        check_all("drop_grant5", 1'b1, 4'd5, 16'h0020, 1'b0);
        reqIn = 16'h0040;
        tick();
        check_all("drop_revoke", 1'b0, 4'd5, 16'h0000, 1'b0);
        tick();
        check_all("drop_grant6", 1'b1, 4'd6, 16'h0040, 1'b0);

        // Reset in the middle of a grant: everything clears and ptr returns to 0.
        reqIn = 16'hFFFF;
        rst   = 1'b1;
        tick();
        check_all("rst_mid", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst = 1'b0;
        tick();
        check_all("rst_first", 1'b1, 4'd0, 16'h0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
